// File: rtl/xrbus_pkg.sv
// XR-BUS shared definitions: header layout, transmitter states and the CRC32 byte step.
// Consumed by xrbus_frame_tx and xrbus_crc32_beat.
package xrbus_pkg;

    localparam int XRBUS_HDR_BITS   = 576;
    localparam int XRBUS_LEN_W      = 10;
    localparam int XRBUS_LEN_LSB    = 520;
    localparam int XRBUS_VERSION_LSB = 530;

    localparam logic [31:0] XRBUS_CRC32_POLY = 32'hEDB8_8320;
    localparam logic [31:0] XRBUS_CRC32_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] XRBUS_CRC32_XOR  = 32'hFFFF_FFFF;

    // Declared MSB first so that module_id lands in hdr[15:0].
    typedef struct packed {
        logic [13:0]            rsvd;
        logic [31:0]            version;
        logic [XRBUS_LEN_W-1:0] len;
        logic [31:0]            sem_hash;
        logic [127:0]           parent_id;
        logic [127:0]           trace_id;
        logic [63:0]            cloud_time;
        logic [63:0]            fabric_time;
        logic [63:0]            device_time;
        logic [7:0]             op_code;
        logic [15:0]            boundary_id;
        logic [15:0]            module_id;
    } xrbus_hdr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2,
        CRC  = 2'd3
    } xrbus_tx_state_e;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h00_0000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ XRBUS_CRC32_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/xrbus_crc32_beat.sv
// Combinational CRC32 update over the keep-enabled bytes of one beat, byte 0 first.
module xrbus_crc32_beat
    import xrbus_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [31:0]         crc_in,
    input  logic [DATA_W-1:0]   data,
    input  logic [DATA_W/8-1:0] keep,
    output logic [31:0]         crc_out
);

    // Fold each enabled byte into the running CRC in ascending byte order
    always_comb begin
        crc_out = crc_in;
        for (int b = 0; b < DATA_W / 8; b++) begin
            if (keep[b]) begin
                crc_out = crc32_byte(crc_out, data[8*b +: 8]);
            end else begin
                crc_out = crc_out;
            end
        end
    end

endmodule

// File: rtl/xrbus_frame_tx.sv
// XR-BUS frame transmitter: header beats, payload beats, then an optional CRC32 trailer.
// CRC trailer is built only when XRBUS_FRAME_TX_CRC_EN is defined.
module xrbus_frame_tx
    import xrbus_pkg::*;
#(
    parameter int DATA_W            = 64,
    parameter int MAX_PAYLOAD_BYTES = 128
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [15:0]                    in_module_id,
    input  logic [15:0]                    in_boundary_id,
    input  logic [7:0]                     in_op_code,
    input  logic [63:0]                    in_device_time,
    input  logic [63:0]                    in_fabric_time,
    input  logic [63:0]                    in_cloud_time,
    input  logic [127:0]                   in_trace_id,
    input  logic [127:0]                   in_parent_id,
    input  logic [31:0]                    in_sem_hash,
    input  logic [31:0]                    in_version,
    input  logic [9:0]                     in_payload_len,
    input  logic [MAX_PAYLOAD_BYTES*8-1:0] in_payload,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_W-1:0]              out_data,
    output logic [DATA_W/8-1:0]            out_keep,
    output logic                           out_sof,
    output logic                           out_eof,
    output logic                           len_err
);

    localparam int BPB           = DATA_W / 8;
    localparam int HDR_BEATS     = XRBUS_HDR_BITS / DATA_W;
    localparam int PAY_BEATS_MAX = (MAX_PAYLOAD_BYTES + BPB - 1) / BPB;
    localparam int PAY_W         = PAY_BEATS_MAX * DATA_W;
    localparam int CNT_W         = 10;
    localparam logic [9:0]       MAX_LEN  = 10'(MAX_PAYLOAD_BYTES);
    localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_BEATS - 1);
`ifdef XRBUS_FRAME_TX_CRC_EN
    localparam xrbus_tx_state_e AFTER_DATA = CRC;
`else
    localparam xrbus_tx_state_e AFTER_DATA = IDLE;
`endif

    if ((XRBUS_HDR_BITS % DATA_W) != 0 || DATA_W < 32 || (DATA_W % 8) != 0) begin : g_bad_data_w
        $fatal(1, "xrbus_frame_tx: DATA_W must divide 576, be >= 32 and a whole number of bytes");
    end
    if (MAX_PAYLOAD_BYTES < 1 || MAX_PAYLOAD_BYTES > 1023) begin : g_bad_max_payload
        $fatal(1, "xrbus_frame_tx: MAX_PAYLOAD_BYTES must be 1..1023");
    end

    xrbus_tx_state_e  state_r, state_nx_s;
    logic [CNT_W-1:0] cnt_r, cnt_nx_s, pay_last_s;
    xrbus_hdr_t       hdr_r, hdr_in_s, hdr_src_s;
    logic [PAY_W-1:0] pay_r, pay_src_s;
    logic [9:0]       len_r, len_in_s, len_src_s;
    logic [11:0]      rem_s;
    logic             accept_s, adv_s;
    logic             in_ready_r, out_valid_r, out_sof_r, out_eof_r, len_err_r;
    logic [DATA_W-1:0] out_data_r, beat_data_s;
    logic [BPB-1:0]   out_keep_r, beat_keep_s;
    logic             beat_valid_s, beat_sof_s, beat_eof_s;

    assign accept_s   = in_valid && in_ready_r;
    assign adv_s      = out_valid_r && out_ready;
    assign len_in_s   = (in_payload_len > MAX_LEN) ? MAX_LEN : in_payload_len;
    assign hdr_src_s  = accept_s ? hdr_in_s : hdr_r;
    assign pay_src_s  = accept_s ? PAY_W'(in_payload) : pay_r;
    assign len_src_s  = accept_s ? len_in_s : len_r;
    // Only consulted in PAY, where len_r is nonzero.
    assign pay_last_s = CNT_W'((32'(len_r) + 32'(BPB) - 32'd1) / 32'(BPB) - 32'd1);

    // Assemble the header from the descriptor fields
    always_comb begin
        hdr_in_s             = '0;
        hdr_in_s.module_id   = in_module_id;
        hdr_in_s.boundary_id = in_boundary_id;
        hdr_in_s.op_code     = in_op_code;
        hdr_in_s.device_time = in_device_time;
        hdr_in_s.fabric_time = in_fabric_time;
        hdr_in_s.cloud_time  = in_cloud_time;
        hdr_in_s.trace_id    = in_trace_id;
        hdr_in_s.parent_id   = in_parent_id;
        hdr_in_s.sem_hash    = in_sem_hash;
        hdr_in_s.len         = len_in_s;
        hdr_in_s.version     = in_version;
    end

`ifdef XRBUS_FRAME_TX_CRC_EN
    logic [31:0] crc_r, crc_upd_s;

    xrbus_crc32_beat #(.DATA_W(DATA_W)) u_crc32_beat (
        .crc_in  (crc_r),
        .data    (out_data_r),
        .keep    (out_keep_r),
        .crc_out (crc_upd_s)
    );

    // Running CRC advances once per consumed header/payload beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_r <= XRBUS_CRC32_INIT;
        end else if (accept_s) begin
            crc_r <= XRBUS_CRC32_INIT;
        end else if (adv_s && (state_r == HDR || state_r == PAY)) begin
            crc_r <= crc_upd_s;
        end else begin
            crc_r <= crc_r;
        end
    end
`endif

    // Next state and beat index; only moves on acceptance or a beat handshake
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nx_s = HDR;
                    cnt_nx_s   = '0;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            HDR: begin
                if (!adv_s) begin
                    state_nx_s = HDR;
                end else if (cnt_r != HDR_LAST) begin
                    cnt_nx_s = cnt_r + CNT_W'(1);
                end else if (len_r != 10'd0) begin
                    state_nx_s = PAY;
                    cnt_nx_s   = '0;
                end else begin
                    state_nx_s = AFTER_DATA;
                    cnt_nx_s   = '0;
                end
            end
            PAY: begin
                if (!adv_s) begin
                    state_nx_s = PAY;
                end else if (cnt_r != pay_last_s) begin
                    cnt_nx_s = cnt_r + CNT_W'(1);
                end else begin
                    state_nx_s = AFTER_DATA;
                    cnt_nx_s   = '0;
                end
            end
            CRC: begin
                if (adv_s) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = CRC;
                end
            end
            default: begin
                state_nx_s = IDLE;
                cnt_nx_s   = '0;
            end
        endcase
    end

    // Contents of the beat that will be presented in the next state
    always_comb begin
        beat_valid_s = 1'b0;
        beat_data_s  = '0;
        beat_keep_s  = '0;
        beat_sof_s   = 1'b0;
        beat_eof_s   = 1'b0;
        rem_s        = 12'd0;
        case (state_nx_s)
            HDR: begin
                beat_valid_s = 1'b1;
                beat_data_s  = hdr_src_s[32'(cnt_nx_s) * DATA_W +: DATA_W];
                beat_keep_s  = '1;
                beat_sof_s   = (cnt_nx_s == '0);
`ifndef XRBUS_FRAME_TX_CRC_EN
                beat_eof_s   = (cnt_nx_s == HDR_LAST) && (len_src_s == 10'd0);
`endif
            end
            PAY: begin
                beat_valid_s = 1'b1;
                rem_s        = {2'b00, len_src_s} - 12'(32'(cnt_nx_s) * BPB);
                for (int b = 0; b < BPB; b++) begin
                    if (12'(b) < rem_s) begin
                        beat_keep_s[b]        = 1'b1;
                        beat_data_s[8*b +: 8] = pay_src_s[32'(cnt_nx_s) * DATA_W + 8*b +: 8];
                    end else begin
                        beat_keep_s[b]        = 1'b0;
                        beat_data_s[8*b +: 8] = 8'h00;
                    end
                end
`ifndef XRBUS_FRAME_TX_CRC_EN
                beat_eof_s   = (rem_s <= 12'(BPB));
`endif
            end
`ifdef XRBUS_FRAME_TX_CRC_EN
            CRC: begin
                beat_valid_s = 1'b1;
                beat_data_s  = DATA_W'(crc_upd_s ^ XRBUS_CRC32_XOR);
                beat_keep_s  = BPB'(4'hF);
                beat_eof_s   = 1'b1;
            end
`endif
            default: begin
                beat_valid_s = 1'b0;
            end
        endcase
    end

    // State, captured descriptor and registered output beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            hdr_r       <= '0;
            pay_r       <= '0;
            len_r       <= 10'd0;
            in_ready_r  <= 1'b0;
            len_err_r   <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_keep_r  <= '0;
            out_sof_r   <= 1'b0;
            out_eof_r   <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            cnt_r      <= cnt_nx_s;
            in_ready_r <= (state_nx_s == IDLE);
            len_err_r  <= accept_s && (in_payload_len > MAX_LEN);
            if (accept_s) begin
                hdr_r <= hdr_in_s;
                pay_r <= pay_src_s;
                len_r <= len_in_s;
            end
            if (accept_s || adv_s) begin
                out_valid_r <= beat_valid_s;
                out_data_r  <= beat_data_s;
                out_keep_r  <= beat_keep_s;
                out_sof_r   <= beat_sof_s;
                out_eof_r   <= beat_eof_s;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_keep  = out_keep_r;
    assign out_sof   = out_sof_r;
    assign out_eof   = out_eof_r;
    assign len_err   = len_err_r;

endmodule
